// File: rtl/dllp_tx_scheduler.sv
// DLLP/TLP link transmit arbiter: Ack/Nak > replay > (starved UpdateFC) > new TLP > UpdateFC, one idle bubble between grants.
// Optional UpdateFC starvation promotion is built only when DLLP_SCHED_FC_PROMOTE_EN is defined.
module dllp_tx_scheduler #(
    parameter int DATA_WIDTH      = 32,
    parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int USER_WIDTH      = 1,
    parameter int FC_STARVE_LIMIT = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic [DATA_WIDTH-1:0] s_axis_rply_tdata_i,
    input  logic [KEEP_WIDTH-1:0] s_axis_rply_tkeep_i,
    input  logic                  s_axis_rply_tvalid_i,
    input  logic                  s_axis_rply_tlast_i,
    input  logic [USER_WIDTH-1:0] s_axis_rply_tuser_i,
    output logic                  s_axis_rply_tready_o,

    input  logic [DATA_WIDTH-1:0] s_axis_tlp_tdata_i,
    input  logic [KEEP_WIDTH-1:0] s_axis_tlp_tkeep_i,
    input  logic                  s_axis_tlp_tvalid_i,
    input  logic                  s_axis_tlp_tlast_i,
    input  logic [USER_WIDTH-1:0] s_axis_tlp_tuser_i,
    output logic                  s_axis_tlp_tready_o,

    input  logic                  acknak_req_i,
    input  logic [31:0]           acknak_data_i,
    output logic                  acknak_gnt_o,
    input  logic                  fc_req_i,
    input  logic [31:0]           fc_data_i,
    output logic                  fc_gnt_o,
    input  logic                  replay_block_i,

    output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep_o,
    output logic                  m_axis_tvalid_o,
    output logic                  m_axis_tlast_o,
    output logic [USER_WIDTH-1:0] m_axis_tuser_o,
    input  logic                  m_axis_tready_i,

    output logic                  fc_starved_o
);

    if (DATA_WIDTH < 32 || KEEP_WIDTH < 4 || FC_STARVE_LIMIT < 1 || FC_STARVE_LIMIT > 255) begin : g_bad_param
        $error("dllp_tx_scheduler: illegal parameter value");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACKNAK = 3'd1,
        ST_FC     = 3'd2,
        ST_RPLY   = 3'd3,
        ST_TLP    = 3'd4
    } state_t;

    state_t state_q, state_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        m_axis_tdata_o       = '0;
        m_axis_tkeep_o       = '0;
        m_axis_tvalid_o      = 1'b0;
        m_axis_tlast_o       = 1'b0;
        m_axis_tuser_o       = '0;
        s_axis_rply_tready_o = 1'b0;
        s_axis_tlp_tready_o  = 1'b0;
        acknak_gnt_o         = 1'b0;
        fc_gnt_o             = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (acknak_req_i)                                 state_d = ST_ACKNAK;
                else if (s_axis_rply_tvalid_i)                    state_d = ST_RPLY;
                else if (fc_starved_o && fc_req_i)                state_d = ST_FC;
                else if (s_axis_tlp_tvalid_i && !replay_block_i)  state_d = ST_TLP;
                else if (fc_req_i)                                state_d = ST_FC;
            end
            // Requester holds the word until the grant, so it is driven straight through.
            ST_ACKNAK, ST_FC: begin
                m_axis_tdata_o[31:0] = (state_q == ST_FC) ? fc_data_i : acknak_data_i;
                m_axis_tkeep_o[3:0]  = 4'hF;
                m_axis_tvalid_o      = 1'b1;
                m_axis_tlast_o       = 1'b1;
                acknak_gnt_o         = (state_q == ST_ACKNAK) && m_axis_tready_i;
                fc_gnt_o             = (state_q == ST_FC) && m_axis_tready_i;
                if (m_axis_tready_i) state_d = ST_IDLE;
            end
            ST_RPLY: begin
                m_axis_tdata_o       = s_axis_rply_tdata_i;
                m_axis_tkeep_o       = s_axis_rply_tkeep_i;
                m_axis_tvalid_o      = s_axis_rply_tvalid_i;
                m_axis_tlast_o       = s_axis_rply_tlast_i;
                m_axis_tuser_o       = s_axis_rply_tuser_i;
                s_axis_rply_tready_o = m_axis_tready_i;
                if (s_axis_rply_tvalid_i && s_axis_rply_tlast_i && m_axis_tready_i) state_d = ST_IDLE;
            end
            ST_TLP: begin
                m_axis_tdata_o       = s_axis_tlp_tdata_i;
                m_axis_tkeep_o       = s_axis_tlp_tkeep_i;
                m_axis_tvalid_o      = s_axis_tlp_tvalid_i;
                m_axis_tlast_o       = s_axis_tlp_tlast_i;
                m_axis_tuser_o       = s_axis_tlp_tuser_i;
                s_axis_tlp_tready_o  = m_axis_tready_i;
                if (s_axis_tlp_tvalid_i && s_axis_tlp_tlast_i && m_axis_tready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef DLLP_SCHED_FC_PROMOTE_EN
    localparam logic [7:0] STARVE_LIMIT = 8'(FC_STARVE_LIMIT);

    logic [7:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!fc_req_i || fc_gnt_o) begin
            starve_cnt_d = 8'd0;
        end else if (state_q != ST_FC && starve_cnt_q != STARVE_LIMIT) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt_q <= 8'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign fc_starved_o = (starve_cnt_q == STARVE_LIMIT);
`else
    assign fc_starved_o = 1'b0;
`endif

endmodule

// File: tb/tb_dllp_tx_scheduler.sv
// Directed bench for dllp_tx_scheduler: queue-driven sources, scoreboard of expected link beats.
module tb_dllp_tx_scheduler;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int UW = 1;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          last;
        logic [UW-1:0] user;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic [KW-1:0] keep;
        logic          last;
        logic [UW-1:0] user;
        logic          ackg;
        logic          fcg;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i;
    logic [DW-1:0] s_axis_rply_tdata_i, s_axis_tlp_tdata_i;
    logic [KW-1:0] s_axis_rply_tkeep_i, s_axis_tlp_tkeep_i;
    logic          s_axis_rply_tvalid_i, s_axis_tlp_tvalid_i;
    logic          s_axis_rply_tlast_i, s_axis_tlp_tlast_i;
    logic [UW-1:0] s_axis_rply_tuser_i, s_axis_tlp_tuser_i;
    logic          s_axis_rply_tready_o, s_axis_tlp_tready_o;
    logic          acknak_req_i, fc_req_i, acknak_gnt_o, fc_gnt_o, replay_block_i;
    logic [31:0]   acknak_data_i, fc_data_i;
    logic [DW-1:0] m_axis_tdata_o;
    logic [KW-1:0] m_axis_tkeep_o;
    logic          m_axis_tvalid_o, m_axis_tlast_o, m_axis_tready_i, fc_starved_o;
    logic [UW-1:0] m_axis_tuser_o;

    dllp_tx_scheduler #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .FC_STARVE_LIMIT(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .s_axis_rply_tdata_i(s_axis_rply_tdata_i), .s_axis_rply_tkeep_i(s_axis_rply_tkeep_i),
        .s_axis_rply_tvalid_i(s_axis_rply_tvalid_i), .s_axis_rply_tlast_i(s_axis_rply_tlast_i),
        .s_axis_rply_tuser_i(s_axis_rply_tuser_i), .s_axis_rply_tready_o(s_axis_rply_tready_o),
        .s_axis_tlp_tdata_i(s_axis_tlp_tdata_i), .s_axis_tlp_tkeep_i(s_axis_tlp_tkeep_i),
        .s_axis_tlp_tvalid_i(s_axis_tlp_tvalid_i), .s_axis_tlp_tlast_i(s_axis_tlp_tlast_i),
        .s_axis_tlp_tuser_i(s_axis_tlp_tuser_i), .s_axis_tlp_tready_o(s_axis_tlp_tready_o),
        .acknak_req_i(acknak_req_i), .acknak_data_i(acknak_data_i), .acknak_gnt_o(acknak_gnt_o),
        .fc_req_i(fc_req_i), .fc_data_i(fc_data_i), .fc_gnt_o(fc_gnt_o),
        .replay_block_i(replay_block_i),
        .m_axis_tdata_o(m_axis_tdata_o), .m_axis_tkeep_o(m_axis_tkeep_o),
        .m_axis_tvalid_o(m_axis_tvalid_o), .m_axis_tlast_o(m_axis_tlast_o),
        .m_axis_tuser_o(m_axis_tuser_o), .m_axis_tready_i(m_axis_tready_i),
        .fc_starved_o(fc_starved_o)
    );

    beat_t       rply_q[$], tlp_q[$];
    logic [31:0] ack_q[$], fc_q[$];
    obs_t        exp_q[$];
    int          hs_log[$];
    int          n_cmp = 0, n_err = 0, cyc = 0;
    bit          mon_en = 1'b0, rply_hold = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] expv);
        n_cmp++;
        assert (got === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic obs_t exp_pass(input beat_t b);
        obs_t o;
        o.dat = b.dat; o.keep = '1; o.last = b.last; o.user = b.user; o.ackg = 1'b0; o.fcg = 1'b0;
        return o;
    endfunction

    function automatic obs_t exp_dllp(input logic [31:0] w, input bit is_fc);
        obs_t o;
        o.dat = {32'h0, w}; o.keep = 8'h0F; o.last = 1'b1; o.user = '0;
        o.ackg = !is_fc; o.fcg = is_fc;
        return o;
    endfunction

    task automatic add_pkt(input bit is_tlp, input int n, input logic [DW-1:0] base, input int nexp);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.dat = base * DW'(i + 1); b.last = (i == n - 1); b.user = is_tlp;
            if (is_tlp) tlp_q.push_back(b); else rply_q.push_back(b);
            if (i < nexp) exp_q.push_back(exp_pass(b));
        end
    endtask

    task automatic add_ack(input logic [31:0] w);
        ack_q.push_back(w); exp_q.push_back(exp_dllp(w, 1'b0));
    endtask

    task automatic add_fc(input logic [31:0] w);
        fc_q.push_back(w); exp_q.push_back(exp_dllp(w, 1'b1));
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while ((exp_q.size() > 0 || rply_q.size() > 0 || tlp_q.size() > 0 ||
                ack_q.size() > 0 || fc_q.size() > 0) && k < 80) begin
            step(); k++;
        end
        chk({tag, "_outstanding"}, exp_q.size(), 0);
        repeat (2) step();
    endtask

    // Upstream sources: advance one entry on each handshake seen in the previous cycle.
    initial begin
        bit hs_r, hs_t, g_a, g_f;
        s_axis_rply_tvalid_i = 1'b0; s_axis_tlp_tvalid_i = 1'b0;
        s_axis_rply_tdata_i = '0; s_axis_tlp_tdata_i = '0;
        s_axis_rply_tkeep_i = '1; s_axis_tlp_tkeep_i = '1;
        s_axis_rply_tlast_i = 1'b0; s_axis_tlp_tlast_i = 1'b0;
        s_axis_rply_tuser_i = '0; s_axis_tlp_tuser_i = '0;
        acknak_req_i = 1'b0; acknak_data_i = '0; fc_req_i = 1'b0; fc_data_i = '0;
        forever begin
            @(negedge clk);
            hs_r = s_axis_rply_tvalid_i && s_axis_rply_tready_o;
            hs_t = s_axis_tlp_tvalid_i && s_axis_tlp_tready_o;
            g_a  = acknak_gnt_o;
            g_f  = fc_gnt_o;
            @(posedge clk); #2;
            if (hs_r && rply_q.size() > 0) void'(rply_q.pop_front());
            if (hs_t && tlp_q.size() > 0) void'(tlp_q.pop_front());
            if (g_a && ack_q.size() > 0) void'(ack_q.pop_front());
            if (g_f && fc_q.size() > 0) void'(fc_q.pop_front());
            s_axis_rply_tvalid_i = (rply_q.size() > 0) && !rply_hold;
            if (rply_q.size() > 0) begin
                s_axis_rply_tdata_i = rply_q[0].dat; s_axis_rply_tlast_i = rply_q[0].last;
                s_axis_rply_tuser_i = rply_q[0].user;
            end
            s_axis_tlp_tvalid_i = (tlp_q.size() > 0);
            if (tlp_q.size() > 0) begin
                s_axis_tlp_tdata_i = tlp_q[0].dat; s_axis_tlp_tlast_i = tlp_q[0].last;
                s_axis_tlp_tuser_i = tlp_q[0].user;
            end
            acknak_req_i  = (ack_q.size() > 0);
            acknak_data_i = (ack_q.size() > 0) ? ack_q[0] : 32'h0;
            fc_req_i      = (fc_q.size() > 0);
            fc_data_i     = (fc_q.size() > 0) ? fc_q[0] : 32'h0;
        end
    end

    // Link monitor: scoreboard on every transfer, stability while stalled, no stray grants.
    obs_t          got, e;
    logic [DW-1:0] stall_dat;
    bit            stall = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            got.dat = m_axis_tdata_o; got.keep = m_axis_tkeep_o; got.last = m_axis_tlast_o;
            got.user = m_axis_tuser_o; got.ackg = acknak_gnt_o; got.fcg = fc_gnt_o;
            if (stall) chk("stall_hold", {m_axis_tvalid_o, m_axis_tdata_o}, {1'b1, stall_dat});
            if (m_axis_tvalid_o && m_axis_tready_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $error("FAIL extra_beat: observed %0h expected no transfer", got);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", got, e);
                    hs_log.push_back(cyc);
                end
            end else begin
                chk("idle_gnt", {acknak_gnt_o, fc_gnt_o}, 2'b00);
            end
            stall     = !rst_i && m_axis_tvalid_o && !m_axis_tready_i;
            stall_dat = m_axis_tdata_o;
        end
    end

    initial begin
        rst_i = 1'b1; m_axis_tready_i = 1'b1; replay_block_i = 1'b0;
        step(); step();
        @(negedge clk);
        chk("rst_tvalid", m_axis_tvalid_o, 1'b0);
        chk("rst_tlast", m_axis_tlast_o, 1'b0);
        chk("rst_treadys", {s_axis_rply_tready_o, s_axis_tlp_tready_o}, 2'b00);
        chk("rst_gnts", {acknak_gnt_o, fc_gnt_o}, 2'b00);
        chk("rst_starved", fc_starved_o, 1'b0);
        mon_en = 1'b1;
        step(); rst_i = 1'b0;
        step();

        // All three sources at once: Ack/Nak, replay, new TLP, one bubble between grants.
        hs_log.delete();
        add_ack(32'hA5A5_0001);
        add_pkt(1'b0, 2, 64'h0000_0000_0000_0100, 2);
        add_pkt(1'b1, 2, 64'h0000_0000_0000_1000, 2);
        drain("prio");
        chk("prio_gap_ack_rply", hs_log[1] - hs_log[0], 2);
        chk("prio_rply_back2back", hs_log[2] - hs_log[1], 1);
        chk("prio_gap_rply_tlp", hs_log[3] - hs_log[2], 2);

        // Ack/Nak arriving mid-packet waits for tlast.
        hs_log.delete();
        add_pkt(1'b1, 4, 64'h0000_0000_0002_0000, 4);
        step(); step();
        add_ack(32'h0000_BEEF);
        drain("nopreempt");
        chk("nopreempt_tlp_span", hs_log[3] - hs_log[0], 3);
        chk("nopreempt_gap_ack", hs_log[4] - hs_log[3], 2);

        // replay_block_i gates new TLPs only.
        replay_block_i = 1'b1;
        add_pkt(1'b1, 2, 64'h0000_0000_0030_0000, 2);
        repeat (3) begin
            @(negedge clk);
            chk("block_tlp_tready", s_axis_tlp_tready_o, 1'b0);
            chk("block_tvalid", m_axis_tvalid_o, 1'b0);
        end
        step(); replay_block_i = 1'b0;
        @(negedge clk);
        chk("unblock_same_cycle", s_axis_tlp_tready_o, 1'b0);
        @(negedge clk);
        chk("unblock_next_cycle", s_axis_tlp_tready_o, 1'b1);
        drain("block");

        // Source gap mid-packet holds the grant with tvalid low.
        add_pkt(1'b0, 3, 64'h0000_0000_0400_0000, 3);
        step(); step();
        rply_hold = 1'b1;
        @(negedge clk);
        chk("gap_tvalid", m_axis_tvalid_o, 1'b0);
        chk("gap_grant_held", s_axis_rply_tready_o, 1'b1);
        step();
        @(negedge clk);
        chk("gap_tvalid_2", m_axis_tvalid_o, 1'b0);
        step(); rply_hold = 1'b0;
        drain("gap");

        // Output backpressure toggling during a replay packet 0x11,0x22,0x33.
        add_pkt(1'b0, 3, 64'h11, 3);
        m_axis_tready_i = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step(); m_axis_tready_i = i[0];
        end
        m_axis_tready_i = 1'b1;
        drain("stall");

        // UpdateFC against a continuous TLP stream.
        hs_log.delete();
        add_pkt(1'b1, 2, 64'h0000_0000_5000_0000, 2);
        add_pkt(1'b1, 2, 64'h0000_0000_6000_0000, 2);
`ifdef DLLP_SCHED_FC_PROMOTE_EN
        add_fc(32'hFC00_0004);
        add_pkt(1'b1, 2, 64'h0000_0000_7000_0000, 2);
`else
        add_pkt(1'b1, 2, 64'h0000_0000_7000_0000, 2);
        add_fc(32'hFC00_0004);
`endif
        repeat (4) @(negedge clk);
        chk("starve_before_limit", fc_starved_o, 1'b0);
        @(negedge clk);
`ifdef DLLP_SCHED_FC_PROMOTE_EN
        chk("starve_at_limit", fc_starved_o, 1'b1);
`else
        chk("starve_at_limit", fc_starved_o, 1'b0);
`endif
        drain("fc");
        chk("starve_cleared", fc_starved_o, 1'b0);

        // Reset on beat 2: packet abandoned, outputs at reset values, Ack/Nak served first.
        add_pkt(1'b1, 4, 64'h0000_0008_0000_0000, 1);
        step(); step();
        rst_i = 1'b1; m_axis_tready_i = 1'b0;
        step();
        rst_i = 1'b0; m_axis_tready_i = 1'b1;
        tlp_q.delete();
        @(negedge clk);
        chk("mrst_tvalid", m_axis_tvalid_o, 1'b0);
        chk("mrst_tlast", m_axis_tlast_o, 1'b0);
        chk("mrst_treadys", {s_axis_rply_tready_o, s_axis_tlp_tready_o}, 2'b00);
        chk("mrst_gnts", {acknak_gnt_o, fc_gnt_o}, 2'b00);
        chk("mrst_starved", fc_starved_o, 1'b0);
        step();
        add_ack(32'h0000_0A0A);
        add_pkt(1'b1, 2, 64'h0000_0009_0000_0000, 2);
        drain("mrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no completion expected finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/dllp_tx_scheduler.md
DLLP_TX_SCHEDULER -- requirements
Module: dllp_tx_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, output and TLP data width; values below 32 are illegal.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, tkeep width.
REQ-003 SHALL have parameter USER_WIDTH, default 1, tuser width.
REQ-004 SHALL have parameter FC_STARVE_LIMIT, default 16, cycles of pending UpdateFC before promotion (range 1..255).
REQ-005 Ports, one clock; reset is synchronous and active-high:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- s_axis_rply_{tdata,tkeep,tvalid,tlast,tuser}_i / s_axis_rply_tready_o  in/out  DATA/KEEP/1/1/USER / 1  replay stream
- s_axis_tlp_{tdata,tkeep,tvalid,tlast,tuser}_i / s_axis_tlp_tready_o  in/out  same  new TLP stream
- acknak_req_i  in  1  Ack/Nak DLLP pending
- acknak_data_i  in  32  Ack/Nak DLLP word
- acknak_gnt_o  out  1  one-cycle pulse when the Ack/Nak beat transfers
- fc_req_i  in  1  UpdateFC DLLP pending
- fc_data_i  in  32  UpdateFC DLLP word
- fc_gnt_o  out  1  one-cycle pulse when the UpdateFC beat transfers
- replay_block_i  in  1  blocks new-TLP grants while high
- m_axis_{tdata,tkeep,tvalid,tlast,tuser}_o / m_axis_tready_i  out/in  DATA/KEEP/1/1/USER / 1  link output
- fc_starved_o  out  1  UpdateFC currently promoted

Function
REQ-006 States: IDLE, ACKNAK, FC, RPLY, TLP.
REQ-007 IDLE SHALL pick in priority order:
- acknak_req_i -> ACKNAK
- s_axis_rply_tvalid_i -> RPLY
- fc_starved_o & fc_req_i -> FC
- s_axis_tlp_tvalid_i & !replay_block_i -> TLP
- fc_req_i -> FC
- else stay in IDLE.
The transition is registered, so one idle bubble separates consecutive grants.
REQ-008 While in IDLE, m_axis_tvalid_o SHALL be 0 and both s_axis tready outputs SHALL be 0.
REQ-009 ACKNAK/FC SHALL drive one beat:
- tdata = {zeros, selected 32-bit word}
- tkeep = low 4 bits set
- tlast = 1
- tuser = 0
- tvalid = 1
On m_axis_tready_i the block SHALL pulse the matching gnt and return to IDLE.
REQ-010 The requester SHALL hold req and data stable until gnt; the block SHALL NOT latch the data.
REQ-011 RPLY/TLP SHALL pass the granted stream through combinationally: m_axis_* = s_axis_*, granted tready = m_axis_tready_i, other tready = 0.
REQ-012 RPLY/TLP SHALL return to IDLE only on the tlast & tvalid & tready handshake.
REQ-013 A packet in progress SHALL NOT be preempted by any request, including acknak_req_i and replay_block_i rising.
REQ-014 A granted source deasserting tvalid mid-packet SHALL hold the state, with m_axis_tvalid_o = 0.
REQ-015 m_axis_tready_i low SHALL hold all outputs stable (AXIS rules).
REQ-016 The starvation counter SHALL be 8 bits:
- increments each cycle fc_req_i=1 and the state is not FC
- saturates at FC_STARVE_LIMIT
- clears on fc_gnt_o or when fc_req_i=0.
fc_starved_o = (counter == FC_STARVE_LIMIT).
REQ-017 Promotion SHALL never place UpdateFC above Ack/Nak or replay.

Reset
REQ-018 On rst_i:
- state = IDLE, counter = 0
- m_axis_tvalid_o = 0, m_axis_tlast_o = 0
- both tready = 0, both gnt = 0, fc_starved_o = 0.
All outputs SHALL take these values the cycle after rst_i is sampled high.
REQ-019 Reset mid-packet SHALL abandon the packet without generating tlast; resumption is the upstream's responsibility.

Configuration
REQ-020 Macro DLLP_SCHED_FC_PROMOTE_EN.
- Defined: REQ-016/REQ-017 promotion is active.
- Undefined: no counter is built, fc_starved_o is tied 0, and FC stays strictly lowest priority.

Verification
REQ-021 acknak_req_i=1, rply tvalid=1 and tlp tvalid=1 together in IDLE, tready=1:
- output order is Ack/Nak beat (acknak_gnt_o pulse), IDLE, replay packet, IDLE, new TLP
- each grant is separated by one idle cycle.
REQ-022 4-beat TLP in progress; acknak_req_i rises on beat 2:
- all 4 TLP beats complete with tlast on beat 4
- Ack/Nak beat follows after one idle cycle.
REQ-023 Macro defined, FC_STARVE_LIMIT=4, fc_req_i held and TLP stream continuously valid:
- fc_starved_o rises after 4 cycles
- FC beat is granted at the next packet boundary ahead of the pending TLP
- counter returns to 0.
REQ-024 replay_block_i=1 with only tlp tvalid=1:
- no grant, tlp tready=0
- on deassert the TLP is granted one cycle later.
REQ-025 m_axis_tready_i toggled 0/1 during a replay packet with data 0x11,0x22,0x33:
- output beats are 0x11,0x22,0x33 exactly once each, held stable while stalled.
REQ-026 rst_i asserted on beat 2 of a TLP:
- next cycle all outputs are at reset values and the state is IDLE
- the subsequent acknak_req_i is served first.
